// File: rtl/pulpemu_rst_seq.sv
// Staged reset sequencer: releases N_DOMAINS active-low resets in order once MMCM lock is stable.
// Define PULPEMU_RST_SW_REQ_EN to honour sw_reset_req_i; otherwise the request input is ignored.
module pulpemu_rst_seq #(
  parameter int N_DOMAINS       = 3,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int STAGE_GAP       = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 ref_clk,
  input  logic                 pad_reset,
  input  logic                 clk_locked_i,
  input  logic                 sw_reset_req_i,
  output logic [N_DOMAINS-1:0] rst_no,
  output logic                 busy_o,
  output logic [1:0]           state_o,
  output logic [7:0]           reset_count_o
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int GW  = $clog2(STAGE_GAP);
  localparam int IW  = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0]  GAP_LAST   = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0]  STAGE_LAST = IW'(N_DOMAINS - 1);

  localparam logic [1:0] S_HOLD    = 2'b00;
  localparam logic [1:0] S_RELEASE = 2'b01;
  localparam logic [1:0] S_RUN     = 2'b10;
  localparam logic [1:0] S_ASSERT  = 2'b11;

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   rst;
  logic                   lock_s;
  logic                   sw_req;
  logic                   abort;

  logic [1:0]     state;
  logic [DBW-1:0] deb_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [IW-1:0]  stage;

  // Internal reset asserts with pad_reset and releases SYNC_STAGES edges later.
  always_ff @(posedge ref_clk or posedge pad_reset) begin
    if (pad_reset) begin
      rst_sync <= '1;
    end else begin
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst = rst_sync[SYNC_STAGES-1];

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      lock_sync <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], clk_locked_i};
    end
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];

`ifdef PULPEMU_RST_SW_REQ_EN
  assign sw_req = sw_reset_req_i;
`else
  assign sw_req = sw_reset_req_i & 1'b0;
`endif

  assign abort = !lock_s || sw_req;

  // Abort beats a same-cycle domain release, and lock loss plus a request count once.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state         <= S_HOLD;
      deb_cnt       <= '0;
      gap_cnt       <= '0;
      stage         <= '0;
      rst_no        <= '0;
      reset_count_o <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (abort) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt <= '0;
            gap_cnt <= '0;
            stage   <= '0;
            state   <= S_RELEASE;
          end else begin
            deb_cnt <= deb_cnt + DBW'(1);
          end
        end
        S_RELEASE, S_RUN: begin
          if (abort) begin
            state   <= S_ASSERT;
            rst_no  <= '0;
            gap_cnt <= '0;
            stage   <= '0;
            if (reset_count_o != 8'hFF) begin
              reset_count_o <= reset_count_o + 8'd1;
            end
          end else if (state == S_RELEASE) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              rst_no  <= rst_no | (N_DOMAINS'(1) << stage);
              if (stage == STAGE_LAST) begin
                stage <= '0;
                state <= S_RUN;
              end else begin
                stage <= stage + IW'(1);
              end
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
        end
        default: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            deb_cnt <= '0;
            state   <= S_HOLD;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
      endcase
    end
  end

  assign state_o = state;
  assign busy_o  = (state != S_RUN);

endmodule

// File: tb/tb_pulpemu_rst_seq.sv
// Directed self-checking bench for pulpemu_rst_seq with N_DOMAINS=3, DEBOUNCE_CYCLES=8, STAGE_GAP=4, SYNC_STAGES=2.
// Scenarios that depend on PULPEMU_RST_SW_REQ_EN are selected by the same macro.
module tb_pulpemu_rst_seq;

  logic       ref_clk;
  logic       pad_reset;
  logic       clk_locked_i;
  logic       sw_reset_req_i;
  logic [2:0] rst_no;
  logic       busy_o;
  logic [1:0] state_o;
  logic [7:0] reset_count_o;

  int n_cmp;
  int n_fail;
  int exp_count;

  pulpemu_rst_seq #(
    .N_DOMAINS(3),
    .DEBOUNCE_CYCLES(8),
    .STAGE_GAP(4),
    .SYNC_STAGES(2)
  ) dut (
    .ref_clk(ref_clk),
    .pad_reset(pad_reset),
    .clk_locked_i(clk_locked_i),
    .sw_reset_req_i(sw_reset_req_i),
    .rst_no(rst_no),
    .busy_o(busy_o),
    .state_o(state_o),
    .reset_count_o(reset_count_o)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge ref_clk);
    #1;
  endtask

  task automatic test_reset;
    pad_reset      = 1'b0;
    clk_locked_i   = 1'b0;
    sw_reset_req_i = 1'b0;
    #2 pad_reset = 1'b1;
    step(3);
    n_cmp++;
    if (rst_no !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_rst_no: got %b want 000", rst_no); end
    n_cmp++;
    if (state_o !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_state: got %b want 00", state_o); end
    n_cmp++;
    if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 1", busy_o); end
    n_cmp++;
    if (reset_count_o !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d want 0", reset_count_o); end
    pad_reset = 1'b0;
    step(5);
    n_cmp++;
    if (state_o !== 2'b00) begin n_fail++; $display("[TB] FAIL post_reset_state: got %b want 00", state_o); end
    exp_count = 0;
  endtask

  // Lock raised just after edge T: domains rise at T+14, T+18, T+22.
  task automatic test_normal_release;
    clk_locked_i = 1'b1;
    step(13);
    n_cmp++;
    if (rst_no !== 3'b000) begin n_fail++; $display("[TB] FAIL rel_t13: got %b want 000", rst_no); end
    n_cmp++;
    if (state_o !== 2'b01) begin n_fail++; $display("[TB] FAIL rel_state_t13: got %b want 01", state_o); end
    step(1);
    n_cmp++;
    if (rst_no !== 3'b001) begin n_fail++; $display("[TB] FAIL rel_t14: got %b want 001", rst_no); end
    step(3);
    n_cmp++;
    if (rst_no !== 3'b001) begin n_fail++; $display("[TB] FAIL rel_t17: got %b want 001", rst_no); end
    step(1);
    n_cmp++;
    if (rst_no !== 3'b011) begin n_fail++; $display("[TB] FAIL rel_t18: got %b want 011", rst_no); end
    step(3);
    n_cmp++;
    if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rel_busy_t21: got %b want 1", busy_o); end
    step(1);
    n_cmp++;
    if (rst_no !== 3'b111) begin n_fail++; $display("[TB] FAIL rel_t22: got %b want 111", rst_no); end
    n_cmp++;
    if (state_o !== 2'b10) begin n_fail++; $display("[TB] FAIL rel_state_t22: got %b want 10", state_o); end
    n_cmp++;
    if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rel_busy_t22: got %b want 0", busy_o); end
    n_cmp++;
    if (reset_count_o !== 8'd0) begin n_fail++; $display("[TB] FAIL rel_count: got %0d want 0", reset_count_o); end
  endtask

`ifdef PULPEMU_RST_SW_REQ_EN
  task automatic test_sw_reset_run;
    sw_reset_req_i = 1'b1;
    step(1);
    sw_reset_req_i = 1'b0;
    exp_count = exp_count + 1;
    n_cmp++;
    if (rst_no !== 3'b000) begin n_fail++; $display("[TB] FAIL sw_rst_no: got %b want 000", rst_no); end
    n_cmp++;
    if (state_o !== 2'b11) begin n_fail++; $display("[TB] FAIL sw_state: got %b want 11", state_o); end
    n_cmp++;
    if (reset_count_o !== exp_count[7:0]) begin n_fail++; $display("[TB] FAIL sw_count: got %0d want %0d", reset_count_o, exp_count); end
    step(3);
    n_cmp++;
    if (state_o !== 2'b11) begin n_fail++; $display("[TB] FAIL sw_assert_len: got %b want 11", state_o); end
    step(1);
    n_cmp++;
    if (state_o !== 2'b00) begin n_fail++; $display("[TB] FAIL sw_hold: got %b want 00", state_o); end
    step(8);
    n_cmp++;
    if (state_o !== 2'b01) begin n_fail++; $display("[TB] FAIL sw_rerel_state: got %b want 01", state_o); end
    step(11);
    n_cmp++;
    if (rst_no !== 3'b011) begin n_fail++; $display("[TB] FAIL sw_rerel_h19: got %b want 011", rst_no); end
    step(1);
    n_cmp++;
    if (rst_no !== 3'b111) begin n_fail++; $display("[TB] FAIL sw_rerel_h20: got %b want 111", rst_no); end
  endtask

  task automatic test_lock_and_sw;
    clk_locked_i = 1'b1;
    step(22);
    n_cmp++;
    if (state_o !== 2'b10) begin n_fail++; $display("[TB] FAIL both_run: got %b want 10", state_o); end
    clk_locked_i = 1'b0;
    step(2);
    sw_reset_req_i = 1'b1;
    step(1);
    sw_reset_req_i = 1'b0;
    exp_count = exp_count + 1;
    n_cmp++;
    if (state_o !== 2'b11) begin n_fail++; $display("[TB] FAIL both_state: got %b want 11", state_o); end
    step(4);
    n_cmp++;
    if (reset_count_o !== exp_count[7:0]) begin n_fail++; $display("[TB] FAIL both_count: got %0d want %0d", reset_count_o, exp_count); end
    n_cmp++;
    if (state_o !== 2'b00) begin n_fail++; $display("[TB] FAIL both_hold: got %b want 00", state_o); end
  endtask
`else
  task automatic test_sw_ignored;
    clk_locked_i = 1'b1;
    step(22);
    n_cmp++;
    if (state_o !== 2'b10) begin n_fail++; $display("[TB] FAIL ign_run: got %b want 10", state_o); end
    sw_reset_req_i = 1'b1;
    step(1);
    sw_reset_req_i = 1'b0;
    step(3);
    n_cmp++;
    if (state_o !== 2'b10) begin n_fail++; $display("[TB] FAIL ign_state: got %b want 10", state_o); end
    n_cmp++;
    if (rst_no !== 3'b111) begin n_fail++; $display("[TB] FAIL ign_rst_no: got %b want 111", rst_no); end
    n_cmp++;
    if (reset_count_o !== exp_count[7:0]) begin n_fail++; $display("[TB] FAIL ign_count: got %0d want %0d", reset_count_o, exp_count); end
  endtask
`endif

  // Starts in RUN: lock loss aborts after 3 edges, then a glitchy relock restarts the debounce.
  task automatic test_lock_glitch;
    clk_locked_i = 1'b0;
    step(2);
    n_cmp++;
    if (rst_no !== 3'b111) begin n_fail++; $display("[TB] FAIL loss_t2: got %b want 111", rst_no); end
    step(1);
    exp_count = exp_count + 1;
    n_cmp++;
    if (rst_no !== 3'b000) begin n_fail++; $display("[TB] FAIL loss_t3: got %b want 000", rst_no); end
    n_cmp++;
    if (reset_count_o !== exp_count[7:0]) begin n_fail++; $display("[TB] FAIL loss_count: got %0d want %0d", reset_count_o, exp_count); end
    step(4);
    n_cmp++;
    if (state_o !== 2'b00) begin n_fail++; $display("[TB] FAIL loss_hold: got %b want 00", state_o); end
    step(2);
    clk_locked_i = 1'b1;
    step(5);
    clk_locked_i = 1'b0;
    step(1);
    clk_locked_i = 1'b1;
    step(13);
    n_cmp++;
    if (rst_no !== 3'b000) begin n_fail++; $display("[TB] FAIL glitch_r13: got %b want 000", rst_no); end
    step(1);
    n_cmp++;
    if (rst_no !== 3'b001) begin n_fail++; $display("[TB] FAIL glitch_r14: got %b want 001", rst_no); end
  endtask

  // Entered with domain 0 just released; the abort lands on the edge domain 1 would release.
  task automatic test_lock_loss_release;
    step(1);
    clk_locked_i = 1'b0;
    step(2);
    n_cmp++;
    if (rst_no !== 3'b001) begin n_fail++; $display("[TB] FAIL mid_d2: got %b want 001", rst_no); end
    step(1);
    exp_count = exp_count + 1;
    n_cmp++;
    if (rst_no !== 3'b000) begin n_fail++; $display("[TB] FAIL mid_d3: got %b want 000", rst_no); end
    n_cmp++;
    if (state_o !== 2'b11) begin n_fail++; $display("[TB] FAIL mid_state: got %b want 11", state_o); end
    n_cmp++;
    if (reset_count_o !== exp_count[7:0]) begin n_fail++; $display("[TB] FAIL mid_count: got %0d want %0d", reset_count_o, exp_count); end
    step(14);
    n_cmp++;
    if (rst_no !== 3'b000) begin n_fail++; $display("[TB] FAIL mid_never: got %b want 000", rst_no); end
    n_cmp++;
    if (state_o !== 2'b00) begin n_fail++; $display("[TB] FAIL mid_hold: got %b want 00", state_o); end
  endtask

  task automatic test_async_reset;
    clk_locked_i = 1'b0;
    step(10);
    clk_locked_i = 1'b1;
    step(22);
    n_cmp++;
    if (state_o !== 2'b10) begin n_fail++; $display("[TB] FAIL async_pre_run: got %b want 10", state_o); end
    #3 pad_reset = 1'b1;
    #1;
    exp_count = 0;
    n_cmp++;
    if (rst_no !== 3'b000) begin n_fail++; $display("[TB] FAIL async_rst_no: got %b want 000", rst_no); end
    n_cmp++;
    if (state_o !== 2'b00) begin n_fail++; $display("[TB] FAIL async_state: got %b want 00", state_o); end
    n_cmp++;
    if (reset_count_o !== 8'd0) begin n_fail++; $display("[TB] FAIL async_count: got %0d want 0", reset_count_o); end
    n_cmp++;
    if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL async_busy: got %b want 1", busy_o); end
    #4 pad_reset = 1'b0;
    clk_locked_i = 1'b0;
    step(4);
  endtask

`ifndef PULPEMU_RST_SW_REQ_EN
  task automatic test_saturation;
    for (int i = 1; i <= 300; i++) begin
      clk_locked_i = 1'b1;
      for (int k = 0; k < 40 && state_o !== 2'b01; k++) step(1);
      n_cmp++;
      if (state_o !== 2'b01) begin
        n_fail++;
        $display("[TB] FAIL sat_wait_release: iter %0d state %b want 01", i, state_o);
        break;
      end
      clk_locked_i = 1'b0;
      for (int k = 0; k < 10 && state_o !== 2'b11; k++) step(1);
      for (int k = 0; k < 10 && state_o !== 2'b00; k++) step(1);
      exp_count = (exp_count >= 255) ? 255 : exp_count + 1;
      if (i == 254 || i == 255 || i == 300) begin
        n_cmp++;
        if (reset_count_o !== exp_count[7:0]) begin
          n_fail++;
          $display("[TB] FAIL sat_count: iter %0d got %0d want %0d", i, reset_count_o, exp_count);
        end
      end
    end
  endtask
`endif

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    exp_count = 0;
    test_reset();
    test_normal_release();
`ifdef PULPEMU_RST_SW_REQ_EN
    test_sw_reset_run();
`endif
    test_lock_glitch();
    test_lock_loss_release();
`ifdef PULPEMU_RST_SW_REQ_EN
    test_lock_and_sw();
`else
    test_sw_ignored();
`endif
    test_async_reset();
`ifndef PULPEMU_RST_SW_REQ_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pulpemu_rst_seq.md
# pulpemu_rst_seq

Parametrised reset sequencer for the FPGA emulation top level. It replaces the single inverted `pad_reset` feed into the SoC with `N_DOMAINS` staged, active-low domain resets. Release waits for a debounced clock-lock indication and proceeds in fixed order. Any lock loss or software reset request re-asserts all domains at once. It sits between the board clock/reset pins (after the differential clock buffer and MMCM) and the `pulp` instance.

## Interface

Parameters:

- `N_DOMAINS`, default 3: number of reset domains. Range 1..8. Domain 0 is released first.
- `DEBOUNCE_CYCLES`, default 1024: consecutive cycles synchronised lock must stay high before release starts. Minimum 2.
- `STAGE_GAP`, default 16: cycles between successive domain releases. This is also the minimum ASSERT duration. Minimum 2.
- `SYNC_STAGES`, default 2: flop depth of the lock synchroniser and of the reset-deassert synchroniser. Minimum 2.

Ports:

- `ref_clk` input, 1: single clock; all logic is on its rising edge.
- `pad_reset` input, 1: asynchronous, active-high reset.
- `clk_locked_i` input, 1: MMCM lock, asynchronous to `ref_clk`.
- `sw_reset_req_i` input, 1: single-cycle synchronous software/debug reset request.
- `rst_no` output, `N_DOMAINS`: per-domain reset, active-low.
- `busy_o` output, 1: high whenever state is not RUN.
- `state_o` output, 2: current FSM state. HOLD=00, RELEASE=01, RUN=10, ASSERT=11.
- `reset_count_o` output, 8: saturating count of ASSERT entries.

## Operation

- **Internal reset.** Asserted asynchronously by `pad_reset`. Deasserted through a `SYNC_STAGES`-deep synchroniser.
- **Lock synchroniser.** `clk_locked_i` passes through `SYNC_STAGES` flops, all reset to 0. All FSM decisions use the synchronised value, `lock_s`.
- **HOLD.** All `rst_no`=0.
  - The debounce counter increments while `lock_s`=1 and clears to 0 on `lock_s`=0.
  - When the counter equals `DEBOUNCE_CYCLES`-1 with `lock_s`=1, go to RELEASE and clear the counter.
  - `sw_reset_req_i` in HOLD clears the debounce counter.
- **RELEASE.** The gap counter increments every cycle.
  - When it equals `STAGE_GAP`-1: set `rst_no[k]`=1, increment k, clear the gap counter.
  - After releasing domain `N_DOMAINS`-1, go to RUN.
  - Released domains stay released while in RELEASE.
- **RUN.** All `rst_no`=1. Stays in RUN until an abort condition.
- **Abort condition.** `lock_s`=0 or an accepted `sw_reset_req_i`, in RELEASE or RUN.
  - Go to ASSERT.
  - All `rst_no` go to 0 on the same edge that enters ASSERT.
  - `reset_count_o` increments, saturating at 255.
- **ASSERT.** All `rst_no`=0 for exactly `STAGE_GAP` cycles, then go to HOLD with the debounce counter at 0.
  - `sw_reset_req_i` and `lock_s` changes during ASSERT are ignored.
- **Simultaneous events.**
  - Lock loss and `sw_reset_req_i` in the same cycle count as one ASSERT entry (+1).
  - Lock loss on the same cycle a domain would release: abort wins, and that domain is not released.
- **Counter widths.** Debounce counter is `$clog2(DEBOUNCE_CYCLES)` bits. Gap counter is `$clog2(STAGE_GAP)` bits. Stage index is `$clog2(N_DOMAINS)` bits, minimum 1. None of them wrap: each is cleared on its terminal value.

## Timing

- **Reset values.** `rst_no`=all 0, `busy_o`=1, `state_o`=00, `reset_count_o`=0, all counters 0.
- **`pad_reset` assertion.** Forces the reset values asynchronously, mid-operation included. On deassertion the FSM starts in HOLD `SYNC_STAGES` edges later.
- **Release latency.** From the first `ref_clk` edge sampling `clk_locked_i`=1, `rst_no[k]` rises after exactly `SYNC_STAGES` + `DEBOUNCE_CYCLES` + `STAGE_GAP`*(k+1) edges.
  - With defaults: domain 0 at 1042, domain 2 at 1074.
- **Abort latency.**
  - From `sw_reset_req_i` sampled high: `rst_no`=0 on that edge's output, i.e. 1 cycle.
  - From `clk_locked_i` falling: `SYNC_STAGES`+1 edges.
- **Outputs.** All outputs are registered; there are no combinational paths from inputs.

## Configuration

- **`PULPEMU_RST_SW_REQ_EN` defined.** `sw_reset_req_i` behaves as described in Operation.
- **`PULPEMU_RST_SW_REQ_EN` undefined.** `sw_reset_req_i` stays as a port but is ignored in every state. Aborts come only from lock loss, and the HOLD debounce-clear-on-request is also removed.

## Test plan

All scenarios use `N_DOMAINS`=3, `DEBOUNCE_CYCLES`=8, `STAGE_GAP`=4, `SYNC_STAGES`=2.

1. **Normal release.** Release `pad_reset`, raise `clk_locked_i` at edge T → `rst_no[0]`/`[1]`/`[2]` rise at T+14/T+18/T+22. `state_o` 10 and `busy_o`=0 from T+22. `reset_count_o`=0.
2. **Lock glitch during debounce.** Lock high 5 cycles, low 1, high → debounce restarts; `rst_no[0]` rises 14 cycles after the second rise.
3. **Software reset in RUN (macro defined).** 1-cycle `sw_reset_req_i` → `rst_no`=000 next cycle, `state_o`=11 for 4 cycles, then HOLD. Re-release completes 20 cycles after HOLD entry. `reset_count_o`=1.
4. **Lock loss mid-RELEASE.** Drop lock after domain 0 is released → all domains 0 at +3 edges, domain 1 never released. Lock loss together with `sw_reset_req_i` → `reset_count_o` +1 only.
5. **Async reset mid-RUN.** Pulse `pad_reset` for half a cycle → `rst_no`=000 immediately, `reset_count_o`=0, `state_o`=00.
6. **Macro undefined.** `sw_reset_req_i` pulses in RUN → no change. Drive 300 lock-loss aborts → `reset_count_o` saturates at 255.
